// File: rtl/mips_cache_writebuffer_v2_if.sv
// Bundle of the cache-store, Avalon drain, lookup and status signals of the write buffer.
// master = cache/bus environment, slave = write buffer.
interface mips_cache_writebuffer_v2_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]       in_addr;
  logic                    in_write;
  logic [DATA_W-1:0]       in_writedata;
  logic [DATA_W/8-1:0]     in_byteenable;
  logic                    active;
  logic                    waitrequest;
  logic [ADDR_W-1:0]       write_addr;
  logic [DATA_W-1:0]       write_data;
  logic [DATA_W/8-1:0]     write_byteenable;
  logic                    write_writeenable;
  logic [ADDR_W-1:0]       lookup_addr;
  logic                    lookup_hit;
  logic [DATA_W-1:0]       lookup_data;
  logic [DATA_W/8-1:0]     lookup_byteenable;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
  logic [1:0]              state_out;

  modport master (
    output in_addr, in_write, in_writedata, in_byteenable, active, waitrequest, lookup_addr,
    input  write_addr, write_data, write_byteenable, write_writeenable,
    input  lookup_hit, lookup_data, lookup_byteenable, count, full, empty, state_out
  );

  modport slave (
    input  in_addr, in_write, in_writedata, in_byteenable, active, waitrequest, lookup_addr,
    output write_addr, write_data, write_byteenable, write_writeenable,
    output lookup_hit, lookup_data, lookup_byteenable, count, full, empty, state_out
  );
endinterface

// File: rtl/mips_cache_writebuffer_v2.sv
// Circular-FIFO write buffer between data cache and Avalon bus, with occupancy count and read lookup.
// Optional same-word store coalescing into the youngest entry is enabled by defining WB_COALESCE_EN.
module mips_cache_writebuffer_v2 #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  mips_cache_writebuffer_v2_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } wb_state_e;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q, last_idx, lk_idx;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] valid_q;
  logic             empty, full, wen, pop, push, merge, store_req;
  wb_state_e        state;
  logic [1:0]       unused_lookup_lsb;

  assign store_req = bus.in_write && (bus.in_byteenable != '0);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign wen       = !empty && bus.active;
  assign pop       = wen && !bus.waitrequest;
  assign last_idx  = tail_q - PTR_W'(1);

`ifdef WB_COALESCE_EN
  // Head entry may already be on the bus, so it is only merged into while not presented.
  assign merge = store_req && valid_q[last_idx]
              && (addr_mem[last_idx][ADDR_W-1:2] == bus.in_addr[ADDR_W-1:2])
              && !((last_idx == head_q) && wen);
`else
  assign merge = 1'b0;
`endif

  assign push = store_req && !full && !merge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset: valid bits and the empty gate mask stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= bus.in_addr;
      data_mem[tail_q] <= bus.in_writedata;
      be_mem[tail_q]   <= bus.in_byteenable;
    end
`ifdef WB_COALESCE_EN
    if (merge) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (bus.in_byteenable[b]) begin
          data_mem[last_idx][8*b +: 8] <= bus.in_writedata[8*b +: 8];
        end
      end
      be_mem[last_idx] <= be_mem[last_idx] | bus.in_byteenable;
    end
`endif
  end

  // Scan from head towards tail so the youngest match overrides older ones.
  always_comb begin
    bus.lookup_hit        = 1'b0;
    bus.lookup_data       = '0;
    bus.lookup_byteenable = '0;
    lk_idx                = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PTR_W'(i);
      if (valid_q[lk_idx] && (addr_mem[lk_idx][ADDR_W-1:2] == bus.lookup_addr[ADDR_W-1:2])) begin
        bus.lookup_hit        = 1'b1;
        bus.lookup_data       = data_mem[lk_idx];
        bus.lookup_byteenable = be_mem[lk_idx];
      end
    end
  end

  assign unused_lookup_lsb = bus.lookup_addr[1:0];

  always_comb begin
    state = ST_PARTIAL;
    if (empty) begin
      state = ST_EMPTY;
    end else if (full) begin
      state = ST_FULL;
    end
  end

  assign bus.write_addr        = empty ? '0 : addr_mem[head_q];
  assign bus.write_data        = empty ? '0 : data_mem[head_q];
  assign bus.write_byteenable  = empty ? '0 : be_mem[head_q];
  assign bus.write_writeenable = wen;
  assign bus.count             = count_q;
  assign bus.full              = full;
  assign bus.empty             = empty;
  assign bus.state_out         = state;
endmodule

// File: tb/tb_mips_cache_writebuffer_v2.sv
// Self-checking bench for mips_cache_writebuffer_v2: vector table, hand corner sequences,
// and random traffic against a queue-based reference model. Honours WB_COALESCE_EN.
module tb_mips_cache_writebuffer_v2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_cache_writebuffer_v2_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) bus ();

  mips_cache_writebuffer_v2 #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        act;
    logic        wreq;
    logic [31:0] laddr;
    int unsigned e_count;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        e_hit;
    logic [31:0] e_ldata;
  } vec_t;

  ent_t        q[$];
  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned push_total = 0;
  int unsigned pop_total  = 0;
  int unsigned flag_drops = 0;
  bit          plan_pop, plan_push, plan_merge;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment-side flag for a push refused on a full buffer (a cache stall violation).
  always @(posedge clk) begin
    if (rst && bus.in_write && (bus.in_byteenable != 4'd0) && bus.full && !plan_merge) begin
      flag_drops++;
      $display("note: store to 0x%08h dropped while full at %0t", bus.in_addr, $time);
    end
  end

  // Compare DUT against the model for the current inputs, then decide this edge's effects.
  task automatic model_check();
    int unsigned sz;
    bit          exp_wen, h, req;
    ent_t        m, hd;
    sz      = q.size();
    exp_wen = (sz != 0) && bus.active;
    hd      = '{a: 32'd0, d: 32'd0, be: 4'd0};
    if (sz != 0) hd = q[0];
    chk("count", bus.count, sz);
    chk("empty", bus.empty, sz == 0);
    chk("full", bus.full, sz == DEPTH);
    chk("state_out", bus.state_out, (sz == 0) ? 0 : (sz == DEPTH) ? 2 : 1);
    chk("write_writeenable", bus.write_writeenable, exp_wen);
    chk("write_addr", bus.write_addr, hd.a);
    chk("write_data", bus.write_data, hd.d);
    chk("write_byteenable", bus.write_byteenable, hd.be);
    chk("head_ptr", dut.head_q, pop_total % DEPTH);
    chk("tail_ptr", dut.tail_q, push_total % DEPTH);
    h = 1'b0;
    m = hd;
    foreach (q[i]) begin
      if (q[i].a[31:2] == bus.lookup_addr[31:2]) begin
        h = 1'b1;
        m = q[i];
      end
    end
    chk("lookup_hit", bus.lookup_hit, h);
    if (h) begin
      chk("lookup_data", bus.lookup_data, m.d);
      chk("lookup_byteenable", bus.lookup_byteenable, m.be);
    end
    req        = bus.in_write && (bus.in_byteenable != 4'd0);
    plan_pop   = exp_wen && !bus.waitrequest;
    plan_merge = 1'b0;
`ifdef WB_COALESCE_EN
    plan_merge = req && (sz != 0) && (q[sz-1].a[31:2] == bus.in_addr[31:2]) && !((sz == 1) && exp_wen);
`endif
    plan_push  = req && !plan_merge && (sz < DEPTH);
  endtask

  task automatic model_apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ent_t e;
    if (plan_merge) begin
      e = q[q.size()-1];
      for (int b = 0; b < 4; b++) if (be[b]) e.d[8*b +: 8] = d[8*b +: 8];
      e.be = e.be | be;
      q[q.size()-1] = e;
    end
    if (plan_pop) begin
      void'(q.pop_front());
      pop_total++;
    end
    if (plan_push) begin
      q.push_back('{a: a, d: d, be: be});
      push_total++;
    end
    plan_merge = 1'b0;
  endtask

  task automatic cycle();
    logic [31:0] a, d;
    logic [3:0]  be;
    model_check();
    a  = bus.in_addr;
    d  = bus.in_writedata;
    be = bus.in_byteenable;
    @(posedge clk);
    #1;
    model_apply(a, d, be);
  endtask

  task automatic step();
    #1;
    cycle();
  endtask

  task automatic set_in(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic act, input logic wreq);
    bus.in_write      = wr;
    bus.in_addr       = a;
    bus.in_writedata  = d;
    bus.in_byteenable = be;
    bus.active        = act;
    bus.waitrequest   = wreq;
  endtask

  task automatic drain();
    set_in(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4 * DEPTH && q.size() != 0; k++) step();
    #1;
    chk("drain_empty", bus.empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[7];
  int unsigned d0;

  initial begin
    tbl[0] = '{1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b0, 32'h100, 0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h100, 32'h11111111, 4'hF, 1'b0, 1'b0, 32'h100, 0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h104, 32'h22222222, 4'h3, 1'b0, 1'b0, 32'h102, 1, 1'b0, 32'h100, 32'h11111111, 4'hF, 1'b1, 32'h11111111};
    tbl[3] = '{1'b1, 32'h108, 32'h33333333, 4'h0, 1'b1, 1'b1, 32'h104, 2, 1'b1, 32'h100, 32'h11111111, 4'hF, 1'b1, 32'h22222222};
    tbl[4] = '{1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h108, 2, 1'b1, 32'h100, 32'h11111111, 4'hF, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h100, 1, 1'b1, 32'h104, 32'h22222222, 4'h3, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h104, 0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h0};

    set_in(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    bus.lookup_addr = 32'd0;
    plan_merge = 1'b0;
    #1;
    chk("rst_wen", bus.write_writeenable, 1'b0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_state", bus.state_out, 2'd0);
    chk("rst_hit", bus.lookup_hit, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].act, tbl[i].wreq);
      bus.lookup_addr = tbl[i].laddr;
      #1;
      chk($sformatf("tbl%0d_count", i), bus.count, tbl[i].e_count);
      chk($sformatf("tbl%0d_wen", i), bus.write_writeenable, tbl[i].e_wen);
      chk($sformatf("tbl%0d_addr", i), bus.write_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_data", i), bus.write_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_be", i), bus.write_byteenable, tbl[i].e_be);
      chk($sformatf("tbl%0d_hit", i), bus.lookup_hit, tbl[i].e_hit);
      if (tbl[i].e_hit) chk($sformatf("tbl%0d_ldata", i), bus.lookup_data, tbl[i].e_ldata);
      cycle();
    end

    // Reset asserted mid-drain with three entries queued.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h600 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0, 1'b0);
      step();
    end
    set_in(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk("rstmid_wen", bus.write_writeenable, 1'b0);
    chk("rstmid_count", bus.count, 0);
    chk("rstmid_empty", bus.empty, 1'b1);
    q.delete();
    push_total = 0;
    pop_total  = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to full with drain disabled; ninth store is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'h100 + 32'(4*i), 32'hD000 + 32'(i), 4'hF, 1'b0, 1'b0);
      step();
    end
    chk("fill_full", bus.full, 1'b1);
    chk("fill_state", bus.state_out, 2'd2);
    d0 = flag_drops;
    set_in(1'b1, 32'h120, 32'hD008, 4'hF, 1'b0, 1'b0);
    step();
    chk("ninth_dropped_flag", flag_drops - d0, 1);
    chk("ninth_count", bus.count, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      #1;
      chk("drain_order", bus.write_addr, 32'h100 + 32'(4*i));
      cycle();
    end
    chk("drain_done_empty", bus.empty, 1'b1);

    // Waitrequest hold on a single entry.
    set_in(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
      #1;
      chk("hold_addr", bus.write_addr, 32'h40);
      chk("hold_data", bus.write_data, 32'hDEADBEEF);
      chk("hold_count", bus.count, 1);
      cycle();
    end
    set_in(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    step();
    chk("hold_pop_empty", bus.empty, 1'b1);

    // Simultaneous push and pop at count 4; tail wraps 7 -> 0.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h500 + 32'(4*i), 32'hE000 + 32'(i), 4'hF, 1'b0, 1'b0);
      step();
    end
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b1, 32'h510 + 32'(4*k), 32'hF000 + 32'(k), 4'hF, 1'b1, 1'b0);
      step();
      chk("pp_count", bus.count, 4);
      chk("pp_tail", dut.tail_q, (5 + k) % DEPTH);
      chk("pp_head", dut.head_q, (1 + k) % DEPTH);
    end
    drain();

`ifndef WB_COALESCE_EN
    set_in(1'b1, 32'h200, 32'hAAAA0000, 4'hF, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h200, 32'h0000BBBB, 4'hF, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    bus.lookup_addr = 32'h202;
    #1;
    chk("lk_hit", bus.lookup_hit, 1'b1);
    chk("lk_data", bus.lookup_data, 32'h0000BBBB);
    chk("lk_count", bus.count, 2);
    cycle();
`else
    set_in(1'b1, 32'h300, 32'h11223344, 4'b0011, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h300, 32'hAABBCCDD, 4'b1100, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("co_count", bus.count, 1);
    chk("co_data", bus.write_data, 32'hAABB3344);
    chk("co_be", bus.write_byteenable, 4'b1111);
    cycle();
`endif
    drain();

    for (int n = 0; n < 2000; n++) begin
      set_in(1'($urandom_range(0, 1)),
             32'h100 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
             $urandom,
             ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
             ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)));
      bus.lookup_addr = 32'h100 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
